axi_stream_rr_arbiter: RTL
==========================

Name: axi_stream_rr_arbiter

Overview:
- Two-input AXI-Stream arbiter with registered output, built on minimal TDATA/TVALID/TREADY streams.
- Shares one downstream stream between in0 (DATA_WIDTH) and in1 (NARROW_WIDTH, zero-extended).
- Round-robin with a burst quantum, so neither input starves the other.
- Replaces the ad-hoc fixed-priority mux in kernels with multiple producers feeding one consumer.

Parameters:
- DATA_WIDTH, 32, width of in0 and output payload.
- NARROW_WIDTH, 16, width of in1 payload; must be ≤ DATA_WIDTH.
- BURST_LEN, 4, maximum consecutive beats accepted from one input per grant; must be ≥ 1.

Ports:
- ap_clk  in  1  sole clock; all logic on rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- s_axis_in0_tdata  in  DATA_WIDTH  input 0 payload.
- s_axis_in0_tvalid  in  1  input 0 valid.
- s_axis_in0_tready  out  1  input 0 ready.
- s_axis_in1_tdata  in  NARROW_WIDTH  input 1 payload.
- s_axis_in1_tvalid  in  1  input 1 valid.
- s_axis_in1_tready  out  1  input 1 ready.
- m_axis_out0_tdata  out  DATA_WIDTH  output payload.
- m_axis_out0_tvalid  out  1  output valid.
- m_axis_out0_tready  in  1  output ready.
- m_axis_out0_src  out  1  source of the current output beat (0 = in0, 1 = in1); valid when tvalid is high.
- busy  out  1  high when any beat is buffered or a grant is held.

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0.
  - State IDLE; rr_last = 1, so in0 wins the first tie.
  - beat_cnt = 0; skid buffer emptied. Buffered beats are discarded on reset mid-operation.
- States: IDLE, GRANT0, GRANT1. The grant is registered.
- s_axis_inK_tready = (state == GRANTK) && !skid_full. The non-granted input always sees tready = 0.
- Input handshake: inK_tvalid && inK_tready.
  - Pushes {src = K, data} into the skid buffer.
  - in1 data is zero-extended to DATA_WIDTH.
  - beat_cnt increments.
- IDLE transitions:
  - Neither input valid: stay in IDLE.
  - One input valid: grant that input.
  - Both valid: grant the input != rr_last.
  - No beat is accepted in the IDLE cycle (one bubble).
- GRANTK transitions, evaluated each cycle:
  - Handshake with beat_cnt == BURST_LEN-1 (quantum exhausted):
    - Other input valid: grant it, beat_cnt = 0, rr_last = K.
    - Otherwise: stay in GRANTK, beat_cnt = 0 (no idle bubble).
  - inK_tvalid low:
    - Other input valid: grant it directly (zero-bubble switch), beat_cnt = 0, rr_last = K.
    - Otherwise: go to IDLE, rr_last = K.
  - Otherwise: hold the grant.
  - Grant never changes while the granted input has tvalid high with no handshake. This keeps AXI valid-hold safe.
- Skid buffer:
  - 2 entries; output taken from the head register.
  - Push and pop in the same cycle are both allowed.
  - skid_full is registered, so tready never depends combinationally on m_axis_out0_tready.
- Latency: a beat accepted at edge N appears on m_axis at cycle N+1.
- Throughput: 1 beat/cycle sustained from one input. Switching between inputs costs no bubble.
- Output hold rule: m_axis_out0_tdata, tvalid and src stay stable while tvalid && !tready.
- Ordering: beats leave in acceptance order; no loss or duplication.
- Width rule: the upper DATA_WIDTH-NARROW_WIDTH bits of in1 beats are 0.
- busy = (state != IDLE) || skid non-empty.

Decomposition:
- Package axi_stream_arb_pkg:
  - grant_state_t enum {IDLE, GRANT0, GRANT1}.
  - SRC_IN0 / SRC_IN1 constants.
  - Function beat_cnt_width(BURST_LEN) = $clog2(BURST_LEN).
- Sub-module axis_skid_buffer, parameterised by payload width (DATA_WIDTH+1, including src). It owns the 2-entry storage, the full/empty flags and the output hold.

Test Plan:
- Only in0 streams 0x1..0x8 with out tready = 1 → output 0x1..0x8 in order, src = 0, one beat/cycle after the IDLE bubble. in0 tready stays high across quantum boundaries.
- Both inputs valid continuously (in0: 0xA0.., in1: 0xB0..), BURST_LEN = 4, tready = 1 → output A0–A3, B0–B3, A4–A7. src toggles every 4 beats; no bubbles after the first beat.
- in1 sends 0xBEEF → output 0x0000BEEF, src = 1.
- Both valid, out tready held 0 for 5 cycles → at most 2 beats accepted. Output data and src stay stable. After release, all beats arrive in order with none lost.
- in0 sends 2 beats then drops valid while in1 is valid → grant switches to in1 with no bubble. in0 is never ready while in1 is granted.
- ap_rst asserted mid-burst with 2 beats buffered → same cycle: tvalid = 0, readys = 0, busy = 0. After release, first tie goes to in0.

Source files
------------

// File: rtl/axi_stream_arb_pkg.sv
// Shared types and constants for the two-input AXI-Stream round-robin arbiter.
package axi_stream_arb_pkg;

  // Grant register encoding: no owner, or input 0 / input 1 owns the stream.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } grant_state_t;

  // Source tag carried alongside every beat through the skid buffer.
  localparam logic SRC_IN0 = 1'b0;
  localparam logic SRC_IN1 = 1'b1;

  // Width needed to count beats inside one burst quantum.
  function automatic int beat_cnt_width(input int burst_len);
    return $clog2(burst_len);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer. The head register drives the output directly, so the
// output payload is held stable while the consumer stalls. The full flag is a
// register so upstream ready never sees the downstream ready combinationally.
module axis_skid_buffer #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] head_p1;
  logic [WIDTH-1:0] tail_p1;
  logic [1:0]       cnt_p1;
  logic [1:0]       cnt_nxt;
  logic             full_p1;
  logic             push_ok;
  logic             pop;

  // A push into a full buffer is ignored; the arbiter never issues one.
  assign push_ok = push && !full_p1;
  assign pop     = (cnt_p1 != 2'd0) && out_ready;

  // Occupancy after this cycle's push/pop pair.
  always_comb begin
    cnt_nxt = cnt_p1;
    case ({push_ok, pop})
      2'b10:   cnt_nxt = cnt_p1 + 2'd1;
      2'b01:   cnt_nxt = cnt_p1 - 2'd1;
      default: cnt_nxt = cnt_p1;
    endcase
  end

  // ---- storage stage: head feeds the output, tail absorbs a stall ----
  // Move data between push input, tail and head and track occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_p1 <= '0;
      tail_p1 <= '0;
      cnt_p1  <= 2'd0;
      full_p1 <= 1'b0;
    end else begin
      case ({push_ok, pop})
        2'b10: begin
          if (cnt_p1 == 2'd0) head_p1 <= push_data;
          else                tail_p1 <= push_data;
        end
        2'b01: begin
          if (cnt_p1 == 2'd2) head_p1 <= tail_p1;
        end
        2'b11: begin
          if (cnt_p1 == 2'd1) begin
            head_p1 <= push_data;
          end else begin
            head_p1 <= tail_p1;
            tail_p1 <= push_data;
          end
        end
        default: ;
      endcase
      cnt_p1  <= cnt_nxt;
      full_p1 <= (cnt_nxt == 2'd2);
    end
  end

  assign out_data  = head_p1;
  assign out_valid = (cnt_p1 != 2'd0);
  assign full      = full_p1;
  assign empty     = (cnt_p1 == 2'd0);

endmodule

// File: rtl/axi_stream_rr_arbiter.sv
// Two-input AXI-Stream arbiter: in0 (full width) and in1 (narrow, zero-extended)
// share one registered output stream. Grants rotate round-robin with a burst
// quantum so a continuously valid input cannot starve the other.
module axi_stream_rr_arbiter
  import axi_stream_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int NARROW_WIDTH = 16,
  parameter int BURST_LEN    = 4
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_in0_tdata,
  input  logic                    s_axis_in0_tvalid,
  output logic                    s_axis_in0_tready,
  input  logic [NARROW_WIDTH-1:0] s_axis_in1_tdata,
  input  logic                    s_axis_in1_tvalid,
  output logic                    s_axis_in1_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_out0_tdata,
  output logic                    m_axis_out0_tvalid,
  input  logic                    m_axis_out0_tready,
  output logic                    m_axis_out0_src,
  output logic                    busy
);

  // A quantum of one still needs a one-bit counter to hold the constant 0.
  localparam int CW_RAW = beat_cnt_width(BURST_LEN);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

  grant_state_t          state;
  logic                  rr_last;
  logic [CW-1:0]         beat_cnt;
  logic                  skid_full;
  logic                  skid_empty;
  logic                  hs0;
  logic                  hs1;
  logic                  push;
  logic [DATA_WIDTH:0]   push_data;
  logic [DATA_WIDTH:0]   out_data;
  logic [DATA_WIDTH-1:0] in1_ext;

  // Ready depends only on registered state, never on the downstream ready.
  assign s_axis_in0_tready = (state == GRANT0) && !skid_full;
  assign s_axis_in1_tready = (state == GRANT1) && !skid_full;

  assign hs0  = s_axis_in0_tvalid && s_axis_in0_tready;
  assign hs1  = s_axis_in1_tvalid && s_axis_in1_tready;
  assign push = hs0 || hs1;

  // Zero-extend the narrow payload to the output width.
  always_comb begin
    in1_ext                   = '0;
    in1_ext[NARROW_WIDTH-1:0] = s_axis_in1_tdata;
  end

  // Select the accepted beat and tag it with its source.
  always_comb begin
    push_data = {SRC_IN1, in1_ext};
    if (hs0) push_data = {SRC_IN0, s_axis_in0_tdata};
  end

  // ---- grant stage: registered owner, burst counter and round-robin pointer ----
  // Grant FSM: pick an owner from IDLE, rotate on quantum expiry or when the
  // owner goes idle, and never move the grant while the owner holds valid.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state    <= IDLE;
      rr_last  <= SRC_IN1;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (s_axis_in0_tvalid && s_axis_in1_tvalid)
            state <= (rr_last == SRC_IN1) ? GRANT0 : GRANT1;
          else if (s_axis_in0_tvalid)
            state <= GRANT0;
          else if (s_axis_in1_tvalid)
            state <= GRANT1;
        end
        GRANT0: begin
          if (hs0 && (beat_cnt == CNT_LAST)) begin
            beat_cnt <= '0;
            if (s_axis_in1_tvalid) begin
              state   <= GRANT1;
              rr_last <= SRC_IN0;
            end
          end else if (!s_axis_in0_tvalid) begin
            beat_cnt <= '0;
            rr_last  <= SRC_IN0;
            state    <= s_axis_in1_tvalid ? GRANT1 : IDLE;
          end else if (hs0) begin
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
        GRANT1: begin
          if (hs1 && (beat_cnt == CNT_LAST)) begin
            beat_cnt <= '0;
            if (s_axis_in0_tvalid) begin
              state   <= GRANT0;
              rr_last <= SRC_IN1;
            end
          end else if (!s_axis_in1_tvalid) begin
            beat_cnt <= '0;
            rr_last  <= SRC_IN1;
            state    <= s_axis_in0_tvalid ? GRANT0 : IDLE;
          end else if (hs1) begin
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  // ---- output stage: skid buffer head is the registered output ----
  axis_skid_buffer #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .push      (push),
    .push_data (push_data),
    .out_ready (m_axis_out0_tready),
    .out_data  (out_data),
    .out_valid (m_axis_out0_tvalid),
    .full      (skid_full),
    .empty     (skid_empty)
  );

  assign m_axis_out0_tdata = out_data[DATA_WIDTH-1:0];
  assign m_axis_out0_src   = out_data[DATA_WIDTH];
  assign busy              = (state != IDLE) || !skid_empty;

endmodule
